edge_event_arbiter: RTL and testbench

- Collects 1-cycle rise/fall pulses from N_CH edge-highlighter instances and queues one pending event per edge type per channel.
- Serialises the pending events onto a single shared valid/ready event port using round-robin arbitration across channels.
- Sits between the per-input edge detectors and the shared event consumer (interrupt controller / event FIFO).
- Reports lost events through per-channel sticky overflow flags.

---
 rtl/edge_event_arbiter_if.sv | 41 ++++
 rtl/edge_event_arbiter.sv | 126 ++++++++++++
 tb/tb_edge_event_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_event_arbiter_if.sv
// Shared event port of edge_event_arbiter: one registered event per transfer.
// With EDGE_ARB_TIMESTAMP_EN defined the port also carries the capture timestamp.
interface edge_event_arbiter_if #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
`ifdef EDGE_ARB_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
);
  // valid/ready: the master raises evt_valid with a stable payload and keeps
  // evt_ch/evt_is_rise/evt_ts unchanged until the edge where evt_valid &
  // evt_ready is seen; that edge transfers exactly one event.
  // evt_ready may be asserted at any time without waiting for evt_valid.
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_is_rise;
`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] evt_ts;
`endif

  modport master (
    output evt_valid,
    output evt_ch,
    output evt_is_rise,
`ifdef EDGE_ARB_TIMESTAMP_EN
    output evt_ts,
`endif
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_is_rise,
`ifdef EDGE_ARB_TIMESTAMP_EN
    input  evt_ts,
`endif
    output evt_ready
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// Queues one rise and one fall event per channel and serialises them round-robin
// onto a registered valid/ready port. Optional timestamps: EDGE_ARB_TIMESTAMP_EN.
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
`ifdef EDGE_ARB_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       rise_pulse,
  input  logic [N_CH-1:0]       fall_pulse,
  input  logic [N_CH-1:0]       ovf_clr,
  output logic [N_CH-1:0]       ovf,
  output logic                  fsm_state,
  edge_event_arbiter_if.master  evt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state, state_n;
  logic [N_CH-1:0]   pend_r, pend_f, fall_first;
  logic [N_CH-1:0]   pend_any, older_rise, sel;
  logic [N_CH-1:0]   r_kept, f_kept, ovf_set;
  logic [CH_W-1:0]   ptr, win, idx;
  logic              found, load;
  logic [CH_W-1:0]   ch_r;
  logic              is_rise_r;

  assign pend_any   = pend_r | pend_f;
  // fall_first only matters while both bits are pending
  assign older_rise = pend_r & (~pend_f | ~fall_first);

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = ptr;
    for (int k = 0; k < N_CH; k++) begin
      idx = (idx == CH_W'(N_CH - 1)) ? '0 : idx + CH_W'(1);
      if (!found && pend_any[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign load = ((state == EMPTY) || evt.evt_ready) && found;
  assign sel  = load ? (N_CH'(1) << win) : '0;

  // A bit consumed this cycle may be re-armed by a pulse in the same cycle.
  assign r_kept  = pend_r & ~(sel & older_rise);
  assign f_kept  = pend_f & ~(sel & ~older_rise);
  assign ovf_set = (rise_pulse & r_kept) | (fall_pulse & f_kept);

  always_comb begin
    state_n = state;
    if (load)
      state_n = FULL;
    else if ((state == FULL) && evt.evt_ready)
      state_n = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r     <= '0;
      pend_f     <= '0;
      fall_first <= '0;
      ovf        <= '0;
      ptr        <= CH_W'(N_CH - 1);
      ch_r       <= '0;
      is_rise_r  <= 1'b0;
    end else begin
      pend_r <= r_kept | rise_pulse;
      pend_f <= f_kept | fall_pulse;
      // Simultaneous rise+fall into an empty channel leaves rise older.
      fall_first <= (r_kept & f_kept & fall_first) |
                    (~(r_kept & f_kept) & f_kept & rise_pulse);
      ovf <= (ovf & ~ovf_clr) | ovf_set;
      if (load) begin
        ptr       <= win;
        ch_r      <= win;
        is_rise_r <= older_rise[win];
      end
    end
  end

`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt, ts_out;
  logic [TS_W-1:0] ts_r [N_CH];
  logic [TS_W-1:0] ts_f [N_CH];

  // Timestamps are written only when their pend bit is newly armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      ts_out <= '0;
      for (int i = 0; i < N_CH; i++) begin
        ts_r[i] <= '0;
        ts_f[i] <= '0;
      end
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      for (int i = 0; i < N_CH; i++) begin
        if (rise_pulse[i] && !r_kept[i]) ts_r[i] <= ts_cnt;
        if (fall_pulse[i] && !f_kept[i]) ts_f[i] <= ts_cnt;
      end
      if (load) ts_out <= older_rise[win] ? ts_r[win] : ts_f[win];
    end
  end

  assign evt.evt_ts = ts_out;
`endif

  assign evt.evt_valid   = (state == FULL);
  assign evt.evt_ch      = ch_r;
  assign evt.evt_is_rise = is_rise_r;
  assign fsm_state       = (state == FULL);

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomised and directed bench for edge_event_arbiter against a queue-based
// model of per-channel pending events and the round-robin output port.
module tb_edge_event_arbiter;
  localparam int N    = 4;
  localparam int CH_W = $clog2(N);
  localparam int TS   = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] in_rise = '0, in_fall = '0, in_clr = '0;
  logic         in_ready = 1'b0;
  logic [N-1:0] ovf;
  logic         fsm_state;

  int n_checks = 0;
  int n_pass   = 0;

  edge_event_arbiter_if #(.N_CH(N)) evt_if ();

  edge_event_arbiter #(.N_CH(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .rise_pulse (in_rise),
    .fall_pulse (in_fall),
    .ovf_clr    (in_clr),
    .ovf        (ovf),
    .fsm_state  (fsm_state),
    .evt        (evt_if)
  );

  always #5 clk = ~clk;

  // Model: per-channel list of pending events (oldest first, 1 = rise).
  bit              mq  [N][$];
  logic [TS-1:0]   mts [N][$];
  bit              m_valid, m_rise;
  int              m_ch, m_ptr;
  logic [TS-1:0]   m_ts, m_cnt;
  logic [N-1:0]    m_ovf;
  logic [CH_W:0]   exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit has(input int c, input bit v);
    for (int j = 0; j < mq[c].size(); j++)
      if (mq[c][j] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rise = 0; m_ch = 0; m_ptr = N - 1;
    m_ts = '0; m_cnt = '0; m_ovf = '0;
    for (int c = 0; c < N; c++) begin
      mq[c].delete();
      mts[c].delete();
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    int win;
    logic [N-1:0] novf;
    win = -1;
    if (!m_valid || in_ready) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (win < 0 && mq[c].size() > 0) win = c;
      end
      if (win >= 0) begin
        m_valid = 1; m_ch = win; m_ptr = win;
        m_rise = mq[win].pop_front();
        m_ts   = mts[win].pop_front();
        exp_q.push_back({m_rise, CH_W'(win)});
      end else begin
        m_valid = 0;
      end
    end
    novf = m_ovf & ~in_clr;
    for (int c = 0; c < N; c++) begin
      if (in_rise[c]) begin
        if (has(c, 1'b1)) novf[c] = 1'b1;
        else begin mq[c].push_back(1'b1); mts[c].push_back(m_cnt); end
      end
      if (in_fall[c]) begin
        if (has(c, 1'b0)) novf[c] = 1'b1;
        else begin mq[c].push_back(1'b0); mts[c].push_back(m_cnt); end
      end
    end
    m_ovf = novf;
    m_cnt = m_cnt + 1'b1;
  endtask

  task automatic compare_outputs();
    check("state", 32'(fsm_state), 32'(m_valid));
    check("valid", 32'(evt_if.evt_valid), 32'(m_valid));
    if (m_valid) begin
      check("ch", 32'(evt_if.evt_ch), 32'(m_ch));
      check("is_rise", 32'(evt_if.evt_is_rise), 32'(m_rise));
`ifdef EDGE_ARB_TIMESTAMP_EN
      check("ts", 32'(evt_if.evt_ts), 32'(m_ts));
`endif
    end
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  // Called at a negedge: drive, score a handshake, step one edge, compare.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] f,
                       input logic rdy, input logic [N-1:0] clr);
    logic [CH_W:0] e;
    in_rise = r; in_fall = f; in_clr = clr; in_ready = rdy;
    evt_if.evt_ready = rdy;
    if (evt_if.evt_valid && rdy) begin
      if (exp_q.size() == 0) check("accept_unexpected", 32'(1), 32'(0));
      else begin
        e = exp_q.pop_front();
        check("accept", 32'({evt_if.evt_is_rise, evt_if.evt_ch}), 32'(e));
      end
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    in_rise = '0; in_fall = '0; in_clr = '0; in_ready = 1'b0;
    evt_if.evt_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 32'(evt_if.evt_valid), 32'(0));
    check("rst_ch", 32'(evt_if.evt_ch), 32'(0));
    check("rst_is_rise", 32'(evt_if.evt_is_rise), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [N-1:0] rnd_vec(input int p);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < p);
    return v;
  endfunction

  initial begin
    evt_if.evt_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single rise on ch2 appears one edge after capture, for one cycle.
    cycle(4'b0100, '0, 1'b1, '0);
    cycle('0, '0, 1'b1, '0);
    check("t1_valid", 32'(evt_if.evt_valid), 32'(1));
    check("t1_ch", 32'(evt_if.evt_ch), 32'(2));
    check("t1_rise", 32'(evt_if.evt_is_rise), 32'(1));
    cycle('0, '0, 1'b1, '0);
    check("t1_once", 32'(evt_if.evt_valid), 32'(0));
    check("t1_ovf", 32'(ovf), 32'(0));

    // All four rise together: granted ch0..ch3 on consecutive cycles.
    do_reset();
    cycle(4'b1111, '0, 1'b1, '0);
    for (int i = 0; i < N; i++) begin
      cycle('0, '0, 1'b1, '0);
      check("t2_ch", 32'(evt_if.evt_ch), 32'(i));
      check("t2_rise", 32'(evt_if.evt_is_rise), 32'(1));
    end
    cycle('0, '0, 1'b1, '0);

    // Port held by ch0; ch1 rise, fall, rise -> third pulse overflows.
    do_reset();
    cycle(4'b0001, '0, 1'b0, '0);
    cycle(4'b0010, '0, 1'b0, '0);
    cycle('0, 4'b0010, 1'b0, '0);
    cycle(4'b0010, '0, 1'b0, '0);
    check("t3_ovf", 32'(ovf[1]), 32'(1));
    for (int i = 0; i < 4; i++) cycle('0, '0, 1'b1, '0);
    cycle('0, '0, 1'b1, 4'b0010);
    check("t3_clr", 32'(ovf[1]), 32'(0));

    // Stall with ch0 rise held for five cycles, then accept once.
    do_reset();
    cycle(4'b0001, '0, 1'b0, '0);
    for (int i = 0; i < 5; i++) cycle('0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle('0, '0, 1'b1, '0);

    // Reset while an event is held and three more are pending.
    do_reset();
    cycle(4'b1111, '0, 1'b0, '0);
    cycle('0, '0, 1'b0, '0);
    check("t5_held", 32'(evt_if.evt_valid), 32'(1));
    do_reset();
    for (int i = 0; i < 5; i++) cycle('0, '0, 1'b1, '0);

    // Timestamp ordering: ch3 fall at count 10, ch0 rise at count 12.
    do_reset();
    cycle(4'b1000, '0, 1'b0, '0);
    for (int i = 0; i < 9; i++) cycle('0, '0, 1'b0, '0);
    cycle('0, 4'b1000, 1'b0, '0);
    cycle('0, '0, 1'b0, '0);
    cycle(4'b0001, '0, 1'b0, '0);
    cycle('0, '0, 1'b0, '0);
    cycle('0, '0, 1'b1, '0);
    check("t6_ch0", 32'(evt_if.evt_ch), 32'(0));
`ifdef EDGE_ARB_TIMESTAMP_EN
    check("t6_ts12", 32'(evt_if.evt_ts), 32'(12));
`endif
    cycle('0, '0, 1'b1, '0);
    check("t6_ch3", 32'(evt_if.evt_ch), 32'(3));
    check("t6_fall", 32'(evt_if.evt_is_rise), 32'(0));
`ifdef EDGE_ARB_TIMESTAMP_EN
    check("t6_ts10", 32'(evt_if.evt_ts), 32'(10));
`endif

    // Random traffic: moderate, sparse with a mid-run reset, then congested.
    for (int ph = 0; ph < 3; ph++) begin
      int p_pulse, p_rdy;
      p_pulse = (ph == 0) ? 30 : (ph == 1) ? 8 : 50;
      p_rdy   = (ph == 0) ? 60 : (ph == 1) ? 90 : 25;
      for (int n = 0; n < 600; n++) begin
        if (ph == 1 && n == 300) do_reset();
        cycle(rnd_vec(p_pulse), rnd_vec(p_pulse),
              logic'($urandom_range(0, 99) < p_rdy), rnd_vec(5));
      end
    end

    for (int i = 0; i < 20; i++) cycle('0, '0, 1'b1, '0);
    check("drain", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
